// File: rtl/lcd_writer.sv
// HD44780-style 4-bit LCD writer: runs power-on init, then sends accepted bytes as two strobed nibbles.
// Latency: accept-to-ready = 1 + 2*(SETUP+E_HIGH+HOLD) + NIBBLE_GAP + post-byte wait cycles.
// Backpressure: req_ready is high only in IDLE after init; req_valid at any other time is ignored.
module lcd_writer #(
    parameter int unsigned POWERUP_CYC       = 750000,
    parameter int unsigned INIT_NIB_WAIT_CYC = 205000,
    parameter int unsigned SETUP_CYC         = 2,
    parameter int unsigned E_HIGH_CYC        = 12,
    parameter int unsigned HOLD_CYC          = 1,
    parameter int unsigned NIBBLE_GAP_CYC    = 50,
    parameter int unsigned CMD_WAIT_CYC      = 2000,
    parameter int unsigned CLEAR_WAIT_CYC    = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       LCDE,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic [3:0] LCDAT
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // A zero-length interval would never reach the terminal count, so clamp to one cycle.
    localparam int unsigned C_PWR = (POWERUP_CYC       == 0) ? 1 : POWERUP_CYC;
    localparam int unsigned C_INW = (INIT_NIB_WAIT_CYC == 0) ? 1 : INIT_NIB_WAIT_CYC;
    localparam int unsigned C_SET = (SETUP_CYC         == 0) ? 1 : SETUP_CYC;
    localparam int unsigned C_EH  = (E_HIGH_CYC        == 0) ? 1 : E_HIGH_CYC;
    localparam int unsigned C_HLD = (HOLD_CYC          == 0) ? 1 : HOLD_CYC;
    localparam int unsigned C_GAP = (NIBBLE_GAP_CYC    == 0) ? 1 : NIBBLE_GAP_CYC;
    localparam int unsigned C_CMD = (CMD_WAIT_CYC      == 0) ? 1 : CMD_WAIT_CYC;
    localparam int unsigned C_CLR = (CLEAR_WAIT_CYC    == 0) ? 1 : CLEAR_WAIT_CYC;

    localparam int unsigned C_MAX = max_u(max_u(max_u(C_PWR, C_INW), max_u(C_SET, C_EH)),
                                          max_u(max_u(C_HLD, C_GAP), max_u(C_CMD, C_CLR)));
    localparam int CW = $clog2(C_MAX + 1);

    localparam logic [CW-1:0] K_ONE = CW'(1);
    localparam logic [CW-1:0] K_PWR = CW'(C_PWR);
    localparam logic [CW-1:0] K_INW = CW'(C_INW);
    localparam logic [CW-1:0] K_SET = CW'(C_SET);
    localparam logic [CW-1:0] K_EH  = CW'(C_EH);
    localparam logic [CW-1:0] K_HLD = CW'(C_HLD);
    localparam logic [CW-1:0] K_GAP = CW'(C_GAP);
    localparam logic [CW-1:0] K_CMD = CW'(C_CMD);
    localparam logic [CW-1:0] K_CLR = CW'(C_CLR);

    typedef enum logic [3:0] {
        PWRUP, INIT_NIB, INIT_CFG, IDLE, SETUP, E_HIGH, HOLD, GAP, WAIT
    } state_t;

    // Power-on init: three 0x3 nibbles switch the controller into 8-bit mode, 0x2 drops it to 4-bit.
    function automatic logic [3:0] init_nibble(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Function set (4-bit, 2 lines), entry mode, display on, clear.
    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            rs_q, rs_d;
    logic            nib_lo_q, nib_lo_d;        // 0: upper nibble next/in flight, 1: lower
    logic            nib_phase_q, nib_phase_d;  // sending the single init nibbles
    logic [1:0]      idx_q, idx_d;              // init nibble / init config byte index
    logic            done_q, done_d;
    logic            lcde_q, lcde_d;
    logic            lcdrs_q, lcdrs_d;
    logic [3:0]      lcdat_q, lcdat_d;
    logic            last;
    logic            clear_cmd;

    assign last      = (cnt_q == K_ONE);
    assign clear_cmd = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));

    // Next-state logic: every timed state runs until the shared down-counter reaches one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - K_ONE;
        byte_d      = byte_q;
        rs_d        = rs_q;
        nib_lo_d    = nib_lo_q;
        nib_phase_d = nib_phase_q;
        idx_d       = idx_q;
        done_d      = done_q;
        lcde_d      = lcde_q;
        lcdrs_d     = lcdrs_q;
        lcdat_d     = lcdat_q;

        case (state_q)
            PWRUP: begin
                if (last) begin
                    state_d     = INIT_NIB;
                    cnt_d       = K_ONE;
                    nib_phase_d = 1'b1;
                    idx_d       = 2'd0;
                end
            end
            INIT_NIB: begin
                // Nibble lines only move here, in GAP exit, with LCDE already low.
                if (last) begin
                    lcdat_d = init_nibble(idx_q);
                    lcdrs_d = 1'b0;
                    state_d = SETUP;
                    cnt_d   = K_SET;
                end
            end
            INIT_CFG: begin
                // Behaves like an accepted command byte; GAP(1) then loads its upper nibble.
                if (last) begin
                    byte_d   = cfg_byte(idx_q);
                    rs_d     = 1'b0;
                    nib_lo_d = 1'b0;
                    state_d  = GAP;
                    cnt_d    = K_ONE;
                end
            end
            IDLE: begin
                cnt_d = cnt_q;
                if (req_valid && done_q) begin
                    byte_d   = req_data;
                    rs_d     = req_rs;
                    nib_lo_d = 1'b0;
                    state_d  = GAP;
                    cnt_d    = K_ONE;
                end
            end
            GAP: begin
                if (last) begin
                    lcdat_d = nib_lo_q ? byte_q[3:0] : byte_q[7:4];
                    lcdrs_d = rs_q;
                    state_d = SETUP;
                    cnt_d   = K_SET;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = E_HIGH;
                    cnt_d   = K_EH;
                    lcde_d  = 1'b1;
                end
            end
            E_HIGH: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = K_HLD;
                    lcde_d  = 1'b0;
                end
            end
            HOLD: begin
                if (last) begin
                    if (nib_phase_q) begin
                        state_d = WAIT;
                        cnt_d   = K_INW;
                    end else if (!nib_lo_q) begin
                        state_d  = GAP;
                        cnt_d    = K_GAP;
                        nib_lo_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = clear_cmd ? K_CLR : K_CMD;
                    end
                end
            end
            WAIT: begin
                if (last) begin
                    if (nib_phase_q) begin
                        cnt_d = K_ONE;
                        if (idx_q == 2'd3) begin
                            nib_phase_d = 1'b0;
                            idx_d       = 2'd0;
                            state_d     = INIT_CFG;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = INIT_NIB;
                        end
                    end else if (!done_q) begin
                        if (idx_q == 2'd3) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = INIT_CFG;
                            cnt_d   = K_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = K_PWR;
            end
        endcase
    end

    // State and output registers; reset drops the strobe immediately and restarts power-up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= PWRUP;
            cnt_q       <= K_PWR;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            nib_lo_q    <= 1'b0;
            nib_phase_q <= 1'b0;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
            lcde_q      <= 1'b0;
            lcdrs_q     <= 1'b0;
            lcdat_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            nib_lo_q    <= nib_lo_d;
            nib_phase_q <= nib_phase_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            lcde_q      <= lcde_d;
            lcdrs_q     <= lcdrs_d;
            lcdat_q     <= lcdat_d;
        end
    end

    assign req_ready = (state_q == IDLE) && done_q;
    assign init_done = done_q;
    assign LCDE      = lcde_q;
    assign LCDRS     = lcdrs_q;
    assign LCDRW     = 1'b0;
    assign LCDAT     = lcdat_q;

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: an LCD-side model checks every strobe, nibble order and ready timing,
// with directed bytes, a continuous-valid stream, and a mid-byte reset.
module tb_lcd_writer;

    localparam int P_PWR = 10;
    localparam int P_INW = 5;
    localparam int P_SET = 2;
    localparam int P_EH  = 3;
    localparam int P_HLD = 1;
    localparam int P_GAP = 2;
    localparam int P_CMD = 4;
    localparam int P_CLR = 8;
    localparam int TMO   = 2000;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs    = 1'b0;
    logic [7:0] req_data  = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       LCDE;
    logic       LCDRS;
    logic       LCDRW;
    logic [3:0] LCDAT;

    lcd_writer #(
        .POWERUP_CYC      (P_PWR),
        .INIT_NIB_WAIT_CYC(P_INW),
        .SETUP_CYC        (P_SET),
        .E_HIGH_CYC       (P_EH),
        .HOLD_CYC         (P_HLD),
        .NIBBLE_GAP_CYC   (P_GAP),
        .CMD_WAIT_CYC     (P_CMD),
        .CLEAR_WAIT_CYC   (P_CLR)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .LCDE     (LCDE),
        .LCDRS    (LCDRS),
        .LCDRW    (LCDRW),
        .LCDAT    (LCDAT)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- LCD-side model ----------------
    typedef struct {
        logic [4:0] v;          // {rs, nibble}
        int         wait_after; // post-byte wait after this nibble, -1 if none
        bit         fin;        // last nibble of init
        bit         usr;        // last nibble of a user byte
    } nib_t;

    nib_t       exp_q[$];
    logic [4:0] obs_q[$];
    int         cyc = 0;
    int         done_at = -1;
    int         ready_at = 0;
    logic       prev_e = 1'b0;
    logic [4:0] prev_cur = 5'h00;
    logic [4:0] latched = 5'h00;
    logic [4:0] cur;
    int         stable_cnt = 0;
    int         hi_cnt = 0;
    int         hold_left = 0;
    bit         exp_done, exp_ready;
    nib_t       e;

    function automatic int wait_for(input logic rs, input logic [7:0] b);
        return (!rs && (b == 8'h01 || b == 8'h02)) ? P_CLR : P_CMD;
    endfunction

    task automatic push_byte(input logic rs, input logic [7:0] b, input bit fin, input bit usr);
        nib_t x;
        x.v = {rs, b[7:4]}; x.wait_after = -1; x.fin = 1'b0; x.usr = 1'b0;
        exp_q.push_back(x);
        x.v = {rs, b[3:0]}; x.wait_after = wait_for(rs, b); x.fin = fin; x.usr = usr;
        exp_q.push_back(x);
    endtask

    task automatic model_reset();
        nib_t x;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            x.v = (i == 3) ? 5'h02 : 5'h03; x.wait_after = -1; x.fin = 1'b0; x.usr = 1'b0;
            exp_q.push_back(x);
        end
        push_byte(1'b0, 8'h28, 1'b0, 1'b0);
        push_byte(1'b0, 8'h06, 1'b0, 1'b0);
        push_byte(1'b0, 8'h0C, 1'b0, 1'b0);
        push_byte(1'b0, 8'h01, 1'b1, 1'b0);
        done_at    = -1;
        ready_at   = 0;
        prev_e     = 1'b0;
        prev_cur   = 5'h00;
        latched    = 5'h00;
        stable_cnt = 0;
        hi_cnt     = 0;
        hold_left  = 0;
    endtask

    // Compare process: sample on the falling edge, away from the active edge.
    always @(negedge clock) begin
        cyc++;
        chk("lcdrw", LCDRW, 0);
        cur = {LCDRS, LCDAT};
        if (reset) begin
            chk("rst_lcde", LCDE, 0);
            chk("rst_lcdat_rs", cur, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_done", init_done, 0);
            model_reset();
        end else begin
            exp_done  = (done_at >= 0) && (cyc >= done_at);
            exp_ready = exp_done && (cyc >= ready_at);
            chk("init_done", init_done, exp_done);
            chk("req_ready", req_ready, exp_ready);
            if (exp_ready && req_valid) begin
                push_byte(req_rs, req_data, 1'b0, 1'b1);
                ready_at = cyc + 1 + 1 + 2 * (P_SET + P_EH + P_HLD) + P_GAP + wait_for(req_rs, req_data);
            end
            if (LCDE && !prev_e) begin
                chk("setup_stable", (cur == prev_cur) && (stable_cnt >= P_SET), 1);
                latched = cur;
                hi_cnt  = 1;
            end else if (LCDE) begin
                chk("strobe_stable", cur, latched);
                hi_cnt++;
            end else if (prev_e) begin
                chk("e_width", hi_cnt, P_EH);
                chk("hold_stable", cur, latched);
                hold_left = P_HLD - 1;
                obs_q.push_back(latched);
                chk("nibble_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("nibble_value", latched, e.v);
                    if (e.fin) done_at = cyc + P_HLD + e.wait_after;
                    if (e.usr) chk("fall_to_ready", cyc + P_HLD + e.wait_after, ready_at);
                end
            end else if (hold_left > 0) begin
                chk("hold_stable", cur, latched);
                hold_left--;
            end
            if (!LCDE) stable_cnt = (cur == prev_cur) ? stable_cnt + 1 : 1;
            else       stable_cnt = 0;
            prev_e   = LCDE;
            prev_cur = cur;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done();
        int n = 0;
        while (!init_done && n < TMO) begin @(posedge clock); #1; n++; end
        chk("init_done_rise", init_done, 1);
        chk("ready_with_done", req_ready, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < TMO) begin @(posedge clock); #1; n++; end
        chk("ready_wait", req_ready, 1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int lat);
        wait_ready();
        req_valid = 1'b1; req_rs = rs; req_data = d;
        @(posedge clock); #1;
        req_valid = 1'b0; req_rs = ~rs; req_data = ~d;
        lat = 0;
        while (!req_ready && lat < 100) begin @(posedge clock); #1; lat++; end
    endtask

    task automatic chk_obs(input int idx, input logic [4:0] exp);
        if (idx < obs_q.size()) chk("obs_nibble", obs_q[idx], exp);
        else                    chk("obs_count", obs_q.size(), idx + 1);
    endtask

    task automatic check_init_seq();
        logic [4:0] seq [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
        chk("init_nibble_count", obs_q.size(), 12);
        for (int i = 0; i < 12; i++) chk_obs(i, seq[i]);
    endtask

    initial begin
        int lat;
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_lcde", LCDE, 0);
        chk("reset_lcdrs", LCDRS, 0);
        chk("reset_lcdrw", LCDRW, 0);
        chk("reset_lcdat", LCDAT, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_done", init_done, 0);
        reset = 1'b0;

        // A request during init must be ignored.
        repeat (20) begin @(posedge clock); #1; end
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        repeat (30) begin @(posedge clock); #1; end
        req_valid = 1'b0;
        wait_done();
        check_init_seq();

        obs_q.delete();
        send(1'b1, 8'h41, lat);
        chk("lat_data_41", lat, 19);
        chk_obs(0, 5'h14);
        chk_obs(1, 5'h11);
        send(1'b0, 8'h01, lat);
        chk("lat_clear_cmd", lat, 23);
        send(1'b1, 8'h01, lat);
        chk("lat_data_01", lat, 19);
        send(1'b0, 8'h02, lat);
        chk("lat_home_cmd", lat, 23);

        // req_valid held high while req_data changes every cycle.
        wait_ready();
        obs_q.delete();
        req_rs = 1'b1; req_data = 8'hA0; req_valid = 1'b1;
        for (int i = 1; i <= 41; i++) begin
            @(posedge clock); #1;
            req_data = 8'(8'hA0 + i);
        end
        req_valid = 1'b0;
        wait_ready();
        chk("stream_nibbles", obs_q.size(), 6);
        chk_obs(0, 5'h1A); chk_obs(1, 5'h10);
        chk_obs(2, 5'h1B); chk_obs(3, 5'h14);
        chk_obs(4, 5'h1C); chk_obs(5, 5'h18);

        // Reset with LCDE high in the middle of a byte.
        wait_ready();
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h7E;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (!LCDE && n < 50) begin @(posedge clock); #1; n++; end
        chk("strobe_before_reset", LCDE, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_lcde", LCDE, 0);
        chk("async_lcdat", LCDAT, 0);
        chk("async_ready", req_ready, 0);
        chk("async_done", init_done, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        obs_q.delete();
        wait_done();
        check_init_seq();
        send(1'b0, 8'h02, lat);
        chk("lat_after_reinit", lat, 23);
        repeat (3) begin @(posedge clock); #1; end
        chk("model_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
